// File: rtl/out_port_write_arbiter.sv
// Round-robin arbiter sharing the out_port write path (address/bus/memory_write) among NREQ requesters.
// Optional grant locking is enabled by defining IO_ARB_LOCK_EN.
module out_port_write_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAX_LOCK = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clock_valid,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*32-1:0]   req_address,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          address,
  output logic [31:0]          bus,
  output logic                 memory_write,
  output logic                 busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] idx;
  logic             found;

  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W:0] s);
    logic [PTR_W:0] r;
    r = (s >= NREQ_W) ? (s - NREQ_W) : s;
    return r[PTR_W-1:0];
  endfunction

  // Scan requesters starting at ptr; first asserted one wins.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap({1'b0, ptr} + (PTR_W+1)'(k));
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef IO_ARB_LOCK_EN
  logic [3:0] lock_cnt;
`else
  logic unused_req_lock;
  assign unused_req_lock = ^req_lock;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      grant        <= '0;
      ack          <= '0;
      address      <= '0;
      bus          <= '0;
      memory_write <= 1'b0;
      busy         <= 1'b0;
`ifdef IO_ARB_LOCK_EN
      lock_cnt     <= '0;
`endif
    end else if (clock_valid) begin
      case (state)
        IDLE: begin
          memory_write <= 1'b0;
          ack          <= '0;
          if (found) begin
            owner   <= pick;
            address <= req_address[{pick, 5'b0} +: 32];
            bus     <= req_data[{pick, 5'b0} +: 32];
            grant   <= NREQ'(1) << pick;
            busy    <= 1'b1;
            state   <= SETUP;
`ifdef IO_ARB_LOCK_EN
            if (pick != owner) lock_cnt <= '0;
`endif
          end
        end
        // Address has been stable for a full cycle; raise the strobe now.
        SETUP: begin
          memory_write <= 1'b1;
          ack          <= grant;
          state        <= WRITE;
        end
        WRITE: begin
          memory_write <= 1'b0;
          ack          <= '0;
          grant        <= '0;
          busy         <= 1'b0;
          state        <= IDLE;
`ifdef IO_ARB_LOCK_EN
          if (req_lock[owner] && (lock_cnt < 4'(MAX_LOCK - 1))) begin
            ptr      <= owner;
            lock_cnt <= lock_cnt + 4'd1;
          end else begin
            ptr      <= wrap({1'b0, owner} + (PTR_W+1)'(1));
            lock_cnt <= '0;
          end
`else
          ptr <= wrap({1'b0, owner} + (PTR_W+1)'(1));
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_write_arbiter.sv
// Directed, table-driven bench for out_port_write_arbiter (NREQ=2), plus hand-written
// stall, late-change, mid-write reset and grant-lock sequences.
module tb_out_port_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_valid;
  logic [1:0]  req;
  logic [1:0]  req_lock;
  logic [31:0] a0, d0, a1, d1;
  logic [1:0]  grant, ack;
  logic [31:0] address, bus;
  logic        memory_write, busy;

  int total = 0;
  int bad   = 0;

  out_port_write_arbiter #(.NREQ(2), .MAX_LOCK(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .clock_valid  (clock_valid),
    .req          (req),
    .req_lock     (req_lock),
    .req_address  ({a1, a0}),
    .req_data     ({d1, d0}),
    .grant        (grant),
    .ack          (ack),
    .address      (address),
    .bus          (bus),
    .memory_write (memory_write),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        cv;
    logic [1:0]  req;
    logic [31:0] a0, d0, a1, d1;
    logic [1:0]  g, ak;
    logic        mw, bz;
    logic [31:0] ad, bs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic [1:0] rq,
                     input logic [31:0] xa0, input logic [31:0] xd0,
                     input logic [31:0] xa1, input logic [31:0] xd1,
                     input logic [1:0] g, input logic [1:0] ak, input logic mw,
                     input logic bz, input logic [31:0] ad, input logic [31:0] bs);
    vec_t v;
    v.rst_n = rst_n; v.cv = 1'b1; v.req = rq;
    v.a0 = xa0; v.d0 = xd0; v.a1 = xa1; v.d1 = xd1;
    v.g = g; v.ak = ak; v.mw = mw; v.bz = bz; v.ad = ad; v.bs = bs;
    vecs.push_back(v);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] g, input logic [1:0] ak,
                       input logic mw, input logic bz, input logic [31:0] ad,
                       input logic [31:0] bs);
    total++;
    if (grant !== g || ack !== ak || memory_write !== mw || busy !== bz ||
        address !== ad || bus !== bs) begin
      bad++;
      $display("FAIL %s: got grant=%b ack=%b mw=%b busy=%b addr=%h bus=%h, want grant=%b ack=%b mw=%b busy=%b addr=%h bus=%h",
               name, grant, ack, memory_write, busy, address, bus, g, ak, mw, bz, ad, bs);
    end
  endtask

  localparam logic [31:0] RA0 = 32'h200, RD0 = 32'h1111_0000;
  localparam logic [31:0] RA1 = 32'h300, RD1 = 32'h2222_0000;

  logic [1:0] lock_exp [10];
  int mw_pulses;

  initial begin
    reset = 1'b0; clock_valid = 1'b1; req = 2'b00; req_lock = 2'b00;
    a0 = '0; d0 = '0; a1 = '0; d1 = '0;

    // reset held with both requesting
    add(0, 2'b11, 32'h100, 32'hA0, 32'h10, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    add(0, 2'b11, 32'h100, 32'hA0, 32'h10, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    // first grant after reset goes to requester 0
    add(1, 2'b11, 32'h100, 32'hA0, 32'h10, 32'hDEADBEEF, 2'b01, 2'b00, 0, 1, 32'h100, 32'hA0);
    add(1, 2'b11, 32'h100, 32'hA0, 32'h10, 32'hDEADBEEF, 2'b01, 2'b01, 1, 1, 32'h100, 32'hA0);
    add(1, 2'b10, 32'h100, 32'hA0, 32'h10, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 32'h100, 32'hA0);
    // single requester 1
    add(1, 2'b10, 32'h100, 32'hA0, 32'h10, 32'hDEADBEEF, 2'b10, 2'b00, 0, 1, 32'h10, 32'hDEADBEEF);
    add(1, 2'b00, 32'h100, 32'hA0, 32'h10, 32'hDEADBEEF, 2'b10, 2'b10, 1, 1, 32'h10, 32'hDEADBEEF);
    add(1, 2'b00, 32'h100, 32'hA0, 32'h10, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 32'h10, 32'hDEADBEEF);
    add(1, 2'b00, 32'h100, 32'hA0, 32'h10, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 32'h10, 32'hDEADBEEF);
    // both held: alternate, one write per three cycles
    for (int w = 0; w < 4; w++) begin
      if (w % 2 == 0) begin
        add(1, 2'b11, RA0, RD0, RA1, RD1, 2'b01, 2'b00, 0, 1, RA0, RD0);
        add(1, 2'b11, RA0, RD0, RA1, RD1, 2'b01, 2'b01, 1, 1, RA0, RD0);
        add(1, 2'b11, RA0, RD0, RA1, RD1, 2'b00, 2'b00, 0, 0, RA0, RD0);
      end else begin
        add(1, 2'b11, RA0, RD0, RA1, RD1, 2'b10, 2'b00, 0, 1, RA1, RD1);
        add(1, 2'b11, RA0, RD0, RA1, RD1, 2'b10, 2'b10, 1, 1, RA1, RD1);
        add(1, (w == 3) ? 2'b00 : 2'b11, RA0, RD0, RA1, RD1, 2'b00, 2'b00, 0, 0, RA1, RD1);
      end
    end

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst_n; clock_valid = vecs[i].cv; req = vecs[i].req;
      a0 = vecs[i].a0; d0 = vecs[i].d0; a1 = vecs[i].a1; d1 = vecs[i].d1;
      step();
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].ak, vecs[i].mw, vecs[i].bz,
            vecs[i].ad, vecs[i].bs);
    end

    // clock_valid stall during SETUP and WRITE (ptr=0 here)
    req = 2'b01; a0 = 32'h40; d0 = 32'h55;
    step(); check("stall_setup", 2'b01, 2'b00, 0, 1, 32'h40, 32'h55);
    clock_valid = 1'b0; req = 2'b00; a0 = 32'hBAD;
    for (int i = 0; i < 5; i++) begin
      step(); check($sformatf("stall_frozen%0d", i), 2'b01, 2'b00, 0, 1, 32'h40, 32'h55);
    end
    clock_valid = 1'b1;
    step(); check("stall_write", 2'b01, 2'b01, 1, 1, 32'h40, 32'h55);
    clock_valid = 1'b0;
    step(); check("stall_write_held", 2'b01, 2'b01, 1, 1, 32'h40, 32'h55);
    clock_valid = 1'b1;
    step(); check("stall_done", 2'b00, 2'b00, 0, 0, 32'h40, 32'h55);

    // request dropped and address changed during SETUP (ptr=1 here)
    req = 2'b10; a1 = 32'h80; d1 = 32'h77;
    step(); check("late_setup", 2'b10, 2'b00, 0, 1, 32'h80, 32'h77);
    req = 2'b00; a1 = 32'h999; d1 = 32'h888;
    mw_pulses = 0;
    step(); check("late_write", 2'b10, 2'b10, 1, 1, 32'h80, 32'h77);
    if (memory_write) mw_pulses++;
    for (int i = 0; i < 3; i++) begin
      step(); if (memory_write) mw_pulses++;
    end
    total++;
    if (mw_pulses != 1) begin
      bad++;
      $display("FAIL late_single_pulse: got %0d memory_write cycles, want 1", mw_pulses);
    end
    check("late_idle", 2'b00, 2'b00, 0, 0, 32'h80, 32'h77);

    // reset in SETUP aborts the write (ptr=0 here)
    req = 2'b01; a0 = 32'hC0; d0 = 32'hC1;
    step(); check("abort_setup", 2'b01, 2'b00, 0, 1, 32'hC0, 32'hC1);
    reset = 1'b0;
    step(); check("abort_reset", 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    reset = 1'b1; req = 2'b00;
    step(); check("abort_no_write", 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);

    // grant sequence with req_lock[0]=1 and both requesting; ptr=0 after reset
`ifdef IO_ARB_LOCK_EN
    lock_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
    lock_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    req = 2'b11; req_lock = 2'b01;
    for (int w = 0; w < 10; w++) begin
      step();
      total++;
      if (grant !== lock_exp[w]) begin
        bad++;
        $display("FAIL lock_grant%0d: got grant=%b, want %b", w, grant, lock_exp[w]);
      end
      step();
      step();
    end
    req = 2'b00; req_lock = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
